// File: rtl/elastic_fifo_buffer.sv
// DEPTH-entry ready/valid elastic buffer with registered ready_in, occupancy count,
// almost-full flag and synchronous flush. Pointers wrap by compare so any DEPTH works.
module elastic_fifo_buffer #(
    parameter type T        = logic [7:0],
    parameter int  DEPTH    = 4,
    parameter int  AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  T                           data_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output T                           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_in_q, ready_in_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_out   = (count_q != '0);
    assign push        = valid_in & ready_in_q;
    assign pop         = valid_out & ready_out;
    assign ready_in    = ready_in_q;
    assign count       = count_q;
    assign data_out    = mem_q[rd_ptr_q];
    assign almost_full = (count_q >= CNT_W'(AF_LEVEL));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ready_in_d = ready_in_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ready_in_d = 1'b1;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
            // ready_in looks at the post-update count so it is never high while full
            ready_in_d = (count_d != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_in_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_in_q <= ready_in_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: doc/elastic_fifo_buffer.md
Name: elastic_fifo_buffer

Overview:
- Parametrised successor to the single-entry skid buffer: a DEPTH-entry ready/valid elastic buffer with a type-parametrised payload.
- Sits between pipeline stages (e.g. fetch→decode, LSU→memory) where more than one entry of slack is needed.
- ready_in is registered: no combinational path from ready_out to ready_in, so long backpressure chains are broken.
- Adds occupancy count, almost-full indication and a synchronous flush for pipeline squash.

Parameters:
- T, logic [7:0], payload type (struct or vector).
- DEPTH, 4, number of entries; legal range 2..64; non-power-of-two allowed.
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous clear of all entries.
- valid_in  in  1  upstream data valid.
- ready_in  out  1  buffer can accept; registered.
- data_in  in  $bits(T)  upstream payload.
- valid_out  out  1  head entry valid.
- ready_out  in  1  downstream accepts.
- data_out  out  $bits(T)  head payload.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.

Behaviour:
- Definitions: push = valid_in & ready_in; pop = valid_out & ready_out. Both are sampled at posedge.
- Reset (asynchronous, active-low) clears rd_ptr, wr_ptr and count to 0.
- Reset values: valid_out 0, ready_in 0, almost_full 0, count 0.
- Storage contents are not reset. data_out is don't-care whenever valid_out = 0.
- After reset deasserts, ready_in rises at the first posedge.
- Storage: circular array indexed by wr_ptr and rd_ptr. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not a power-of-two mask.
- data_out = mem[rd_ptr], driven from registers only.
- valid_out = (count != 0).
- ready_in: registered copy of (next_count != DEPTH), where next_count is the count value after the current cycle's update.
- Latency: a word pushed at edge N appears on valid_out/data_out after edge N (one cycle). There is no same-cycle bypass.
- Throughput: one word per cycle sustained with ready_out held at 1.
- Count update: push & !pop → +1; pop & !push → -1; push & pop → unchanged (write at wr_ptr and read at rd_ptr both happen).
- Full (count == DEPTH): ready_in = 0, even if a pop happens that cycle. ready_in rises on the edge after the first pop.
- Empty (count == 0): valid_out = 0. A push and no pop → count = 1 next cycle.
- Ordering: strict FIFO. A payload presented while not accepted must not be captured.
- Upstream protocol: valid_in must stay high with data_in stable until push. Downstream may toggle ready_out freely.
- almost_full is combinational from count.
- Flush: synchronous, with priority over push and pop in the same cycle.
  - Next state: count 0, pointers 0, valid_out 0.
  - Any word handshaken on the flush cycle is discarded; upstream must also squash it.
  - ready_in is 1 after the flush edge.
- Reset asserted mid-transfer: all queued data is lost immediately and outputs take reset values asynchronously.
- count must never exceed DEPTH or underflow. The bench asserts this every cycle.

Test Plan:
- Pass-through: DEPTH=4, ready_out=1, push 0xA0,0xA1,0xA2 on back-to-back cycles → out 0xA0,0xA1,0xA2 in order, each one cycle after accept; count ≤ 1.
- Fill/backpressure: ready_out=0, push 0xB0..0xB5 → 4 accepted; ready_in=0 once count=4; almost_full=1 from count=3; set ready_out=1 → 0xB0..0xB5 delivered in order with no loss.
- Simultaneous push/pop at full: count=4, valid_in=1, ready_out=1 → cycle 1: pop only, count 3; next cycle: push+pop, count stays 3; ready_in never asserts while count=4.
- Wrap-around, DEPTH=3 (non-power-of-two): stream 0x00..0x0F with random ready_out (50%) → scoreboard matches all 16 words in order.
- Flush: count=3 holding 0xC0..0xC2, assert flush with valid_in=1 and data 0xC3 → next cycle count=0, valid_out=0; 0xC3 never emerges; next push 0xD0 is output first.
- Async reset: count=2, drive reset=0 between edges → valid_out, ready_in and count go to 0 immediately; after release ready_in=1 on the first edge; push 0xE0 → out 0xE0.
